// File: rtl/disp_filter_pkg.sv
// Shared types and width helpers for the disparity window averager.
// Optional round-to-nearest divider mode is enabled with DISP_ROUND_EN.
package disp_filter_pkg;
  localparam int CONF_BITS = 8;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} avg_state_t;

  function automatic int num_w(input int disp_bits, input int win);
    return CONF_BITS + disp_bits + $clog2(win);
  endfunction

  function automatic int den_w(input int win);
    return CONF_BITS + $clog2(win);
  endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring bit-serial divider, one quotient bit per cycle, MSB first.
// DISP_ROUND_EN adds one extra iteration and saturates the quotient.
module seq_divider
  import disp_filter_pkg::*;
#(
  parameter int NW = 15,
  parameter int DW = 10,
  parameter int QW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);
`ifdef DISP_ROUND_EN
  localparam int ITER = QW + 1;
`else
  localparam int ITER = QW;
`endif
  localparam int XW = NW + ITER;
  localparam int KW = $clog2(ITER + 1);

  avg_state_t      r_state;
  logic [NW-1:0]   r_rem;
  logic [DW-1:0]   r_den;
  logic [ITER-1:0] r_q;
  logic [KW-1:0]   r_k;

  logic [XW-1:0]   w_dsh;
  logic            w_ge;

  assign w_dsh = XW'(r_den) << r_k;
  assign w_ge  = XW'(r_rem) >= w_dsh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_den   <= '0;
      r_q     <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_rem   <= num;
          r_den   <= den;
          r_q     <= '0;
          r_k     <= KW'(ITER - 1);
          r_state <= DIVIDE;
        end
        DIVIDE: begin
          // k counts down, so shifting left places quotient bits MSB first
          r_q <= {r_q[ITER-2:0], w_ge};
          if (w_ge) r_rem <= r_rem - NW'(w_dsh);
          if (r_k == '0) r_state <= DONE;
          else           r_k     <= r_k - KW'(1);
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

`ifdef DISP_ROUND_EN
  assign quotient = (r_den == '0) ? '0 : (r_q[QW] ? '1 : r_q[QW-1:0]);
`else
  assign quotient = (r_den == '0) ? '0 : r_q;
`endif
endmodule

// File: rtl/disp_window_averager.sv
// Windowed confidence-weighted disparity mean; closes windows at WIN samples or row end.
// Define DISP_ROUND_EN for round-to-nearest, saturating quotient.
module disp_window_averager
  import disp_filter_pkg::*;
#(
  parameter int DISP_BITS = 5,
  parameter int WIN       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CONF_BITS+DISP_BITS-1:0] disp_conf_in,
  input  logic [CONF_BITS-1:0]          conf_in,
  input  logic                          in_valid,
  input  logic                          row_end,
  output logic [DISP_BITS-1:0]          disp_out,
  output logic [CONF_BITS-1:0]          conf_out,
  output logic                          out_valid,
  output logic                          overrun
);
  localparam int LW = $clog2(WIN);
  localparam int NW = num_w(DISP_BITS, WIN);
  localparam int DW = den_w(WIN);

  logic [NW-1:0]        r_num;
  logic [DW-1:0]        r_den;
  logic [LW-1:0]        r_cnt;
  logic [CONF_BITS-1:0] r_conf;

  logic [NW-1:0]        w_num_sum, w_div_num;
  logic [DW-1:0]        w_den_sum;
  logic                 w_close, w_start, w_busy, w_done;
  logic [DISP_BITS-1:0] w_quot;

  assign w_num_sum = r_num + NW'(disp_conf_in);
  assign w_den_sum = r_den + DW'(conf_in);
  assign w_close   = in_valid && ((r_cnt == LW'(WIN - 1)) || row_end);
  assign w_start   = w_close && !w_busy;
`ifdef DISP_ROUND_EN
  assign w_div_num = w_num_sum + NW'(w_den_sum >> 1);
`else
  assign w_div_num = w_num_sum;
`endif

  seq_divider #(.NW(NW), .DW(DW), .QW(DISP_BITS)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .num      (w_div_num),
    .den      (w_den_sum),
    .busy     (w_busy),
    .done     (w_done),
    .quotient (w_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num     <= '0;
      r_den     <= '0;
      r_cnt     <= '0;
      r_conf    <= '0;
      disp_out  <= '0;
      conf_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        if (w_close) begin
          r_num <= '0;
          r_den <= '0;
          r_cnt <= '0;
        end else begin
          r_num <= w_num_sum;
          r_den <= w_den_sum;
          r_cnt <= r_cnt + LW'(1);
        end
      end
      // conf is latched only for accepted windows so a drop cannot corrupt the in-flight result
      if (w_start) r_conf <= CONF_BITS'(w_den_sum >> LW);
      if (w_close && w_busy) overrun <= 1'b1;
      out_valid <= w_done;
      if (w_done) begin
        disp_out <= w_quot;
        conf_out <= r_conf;
      end
    end
  end
endmodule

// File: tb/tb_disp_window_averager.sv
// Scoreboard bench for disp_window_averager: window model predicts results, monitor compares.
module tb_disp_window_averager;
  localparam int DB  = 5;
  localparam int WIN = 4;
`ifdef DISP_ROUND_EN
  localparam int ITER = DB + 1;
`else
  localparam int ITER = DB;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] disp_conf_in;
  logic [7:0]  conf_in;
  logic        in_valid, row_end;
  logic [4:0]  disp_out;
  logic [7:0]  conf_out;
  logic        out_valid, overrun;

  always #5 clk = ~clk;

  disp_window_averager #(.DISP_BITS(DB), .WIN(WIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .disp_conf_in (disp_conf_in),
    .conf_in      (conf_in),
    .in_valid     (in_valid),
    .row_end      (row_end),
    .disp_out     (disp_out),
    .conf_out     (conf_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  typedef struct {int disp; int conf; int due;} exp_t;
  exp_t q[$];

  int  total = 0, bad = 0;
  int  edge_no = 0, next_free = 0;
  int  wnum = 0, wden = 0, wcnt = 0;
  bit  exp_ovr = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, edge_no);
    end
  endtask

  function automatic int ref_mean(input int num, input int den);
    int r;
    if (den == 0) return 0;
`ifdef DISP_ROUND_EN
    r = (num + den / 2) / den;
    if (r > 31) r = 31;
`else
    r = num / den;
`endif
    return r;
  endfunction

  // One clock: drive inputs, take the edge, then advance the window model.
  task automatic step(input bit v, input bit re, input int d, input int c, input bit rst = 1'b0);
    reset        = rst;
    in_valid     = v;
    row_end      = re;
    conf_in      = 8'(c);
    disp_conf_in = 13'(d * c);
    @(posedge clk);
    edge_no++;
    if (rst) begin
      q.delete();
      wnum = 0; wden = 0; wcnt = 0;
      exp_ovr = 1'b0;
      next_free = 0;
    end else if (v) begin
      wnum += d * c;
      wden += c;
      wcnt++;
      if (wcnt == WIN || re) begin
        if (edge_no >= next_free) begin
          q.push_back('{ref_mean(wnum, wden), wden / WIN, edge_no + ITER + 1});
          next_free = edge_no + ITER + 2;
        end else begin
          exp_ovr = 1'b1;
        end
        wnum = 0; wden = 0; wcnt = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_disp"}, int'(disp_out), 0);
    chk({tag, "_conf"}, int'(conf_out), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", int'(out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("disp_out", int'(disp_out), e.disp);
        chk("conf_out", int'(conf_out), e.conf);
        chk("latency_edge", edge_no, e.due);
      end
    end else if (q.size() > 0 && q[0].due < edge_no) begin
      chk("missed_valid", edge_no, q[0].due);
      void'(q.pop_front());
    end
    chk("overrun", int'(overrun), int'(exp_ovr));
  end

  initial begin
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check_zero_outputs("reset");

    // uniform window
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10, 50);
    idle(ITER + 3);
    // mixed window
    step(1'b1, 1'b0, 4, 100); step(1'b1, 1'b0, 20, 20);
    step(1'b1, 1'b0, 4, 100); step(1'b1, 1'b0, 20, 20);
    idle(ITER + 3);
    // row end on second sample, then a full window restarting from zero
    step(1'b1, 1'b0, 8, 60); step(1'b1, 1'b1, 16, 60);
    idle(ITER + 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7 + i, 30 * i + 5);
    idle(ITER + 3);
    // row_end without in_valid must be ignored
    step(1'b1, 1'b0, 3, 90); step(1'b0, 1'b1, 31, 255);
    step(1'b1, 1'b0, 9, 40); step(1'b1, 1'b0, 12, 70); step(1'b1, 1'b0, 1, 200);
    idle(ITER + 3);
    // zero confidence
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i * 5, 0);
    idle(ITER + 3);
    // back-to-back row ends: second window dropped, overrun sticks
    step(1'b1, 1'b1, 20, 100); step(1'b1, 1'b1, 5, 100);
    idle(ITER + 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 31, 255);
    idle(ITER + 3);

    // reset during the divide
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 15, 80);
    idle(2);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check_zero_outputs("midreset");
    idle(ITER + 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 22, 33);
    idle(ITER + 3);

    // random dense traffic (frequent drops)
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 31),
           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255));
    idle(ITER + 3);
    // random sparse traffic after a reset
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 31),
           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255));
    idle(ITER + 6);
    chk("queue_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
